// File: rtl/vo_timing_gen.sv
// ---------------------------------------------------------------------------
// vo_timing_gen
//
// Video output raster generator and DMA return-data aligner.
// Counts the raster (active, front porch, sync, back porch on each axis),
// issues frame/pixel requests to the DMA read side, delays sync and blanking
// by the DMA read latency so they line up with the returned pixels, expands
// RGB565 to RGB888 and flags underflow/overflow of the returned stream.
//
// Ports:
//   video_clk   pixel clock, all logic on rising edge
//   rst         asynchronous active-high reset
//   enable      run request; stopping only takes effect at frame end
//   err_clr     synchronous clear of underflow/overflow/err_cnt
//   vo_vs       frame request to DMA (vertical sync lines)
//   vo_de       pixel request to DMA (active pixels)
//   video_de    DMA returned-data valid
//   video_data  DMA returned pixel, RGB565
//   rgb_vs/hs/de, rgb_r/g/b   aligned syncs, enable and RGB888 pixel
//   running     timing counters active
//   underflow   sticky: expected pixel did not arrive
//   overflow    sticky: pixel arrived when none was expected
//   err_cnt     saturating count of mismatched cycles
//
// State | Meaning
// ------+-----------------------------------------------------------------
// IDLE  | counters held at 0, requests low, waiting for enable
// RUN   | raster counting; leaves only at the last pixel of a frame
// ---------------------------------------------------------------------------
module vo_timing_gen #(
    parameter int H_DISP = 1280,
    parameter int H_FP   = 110,
    parameter int H_SYNC = 40,
    parameter int H_BP   = 220,
    parameter int V_DISP = 720,
    parameter int V_FP   = 5,
    parameter int V_SYNC = 5,
    parameter int V_BP   = 20,
    parameter int RD_LAT = 2
) (
    input  logic        video_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        err_clr,
    output logic        vo_vs,
    output logic        vo_de,
    input  logic        video_de,
    input  logic [15:0] video_data,
    output logic        rgb_vs,
    output logic        rgb_hs,
    output logic        rgb_de,
    output logic [7:0]  rgb_r,
    output logic [7:0]  rgb_g,
    output logic [7:0]  rgb_b,
    output logic        running,
    output logic        underflow,
    output logic        overflow,
    output logic [15:0] err_cnt
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_END = 12'(H_DISP);
    localparam logic [11:0] H_SYN_BEG = 12'(H_DISP + H_FP);
    localparam logic [11:0] H_SYN_END = 12'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT_END = 12'(V_DISP);
    localparam logic [11:0] V_SYN_BEG = 12'(V_DISP + V_FP);
    localparam logic [11:0] V_SYN_END = 12'(V_DISP + V_FP + V_SYNC - 1);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        hs_req;
    logic        de_raw;
    logic        hs_raw;
    logic        vs_raw;
    logic        frame_end;
    logic        go_idle;

    always_comb begin
        de_raw    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hs_raw    = (h_cnt >= H_SYN_BEG) && (h_cnt <= H_SYN_END);
        vs_raw    = (v_cnt >= V_SYN_BEG) && (v_cnt <= V_SYN_END);
        frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
        go_idle   = (state == RUN) && frame_end && !enable;
    end

    assign running = (state == RUN);

    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            h_cnt  <= '0;
            v_cnt  <= '0;
            vo_de  <= 1'b0;
            vo_vs  <= 1'b0;
            hs_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    h_cnt  <= '0;
                    v_cnt  <= '0;
                    vo_de  <= 1'b0;
                    vo_vs  <= 1'b0;
                    hs_req <= 1'b0;
                    if (enable)
                        state <= RUN;
                end
                RUN: begin
                    vo_de  <= de_raw;
                    vo_vs  <= vs_raw;
                    hs_req <= hs_raw;
                    if (h_cnt == H_LAST) begin
                        h_cnt <= '0;
                        if (v_cnt == V_LAST) begin
                            v_cnt <= '0;
                            if (!enable)
                                state <= IDLE;
                        end else begin
                            v_cnt <= v_cnt + 12'd1;
                        end
                    end else begin
                        h_cnt <= h_cnt + 12'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Delay line matching the DMA read latency. The valid bit is dropped on
    // the way back to IDLE; syncs just drain through.
    logic [RD_LAT-1:0] de_sr;
    logic [RD_LAT-1:0] hs_sr;
    logic [RD_LAT-1:0] vs_sr;

    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            de_sr <= '0;
            hs_sr <= '0;
            vs_sr <= '0;
        end else begin
            hs_sr[0] <= hs_req;
            vs_sr[0] <= vo_vs;
            for (int i = 1; i < RD_LAT; i++) begin
                hs_sr[i] <= hs_sr[i-1];
                vs_sr[i] <= vs_sr[i-1];
            end
            if (go_idle) begin
                de_sr <= '0;
            end else begin
                de_sr[0] <= vo_de;
                for (int i = 1; i < RD_LAT; i++)
                    de_sr[i] <= de_sr[i-1];
            end
        end
    end

    logic de_d;
    logic pix_ok;
    logic mismatch;

    always_comb begin
        de_d     = de_sr[RD_LAT-1];
        pix_ok   = de_d && video_de;
        mismatch = de_d ^ video_de;
    end

    // rgb_de follows the raster even on underflow so downstream timing never
    // shifts; the missing pixel is sent black instead.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            rgb_de <= 1'b0;
            rgb_hs <= 1'b0;
            rgb_vs <= 1'b0;
            rgb_r  <= '0;
            rgb_g  <= '0;
            rgb_b  <= '0;
        end else begin
            rgb_de <= de_d;
            rgb_hs <= hs_sr[RD_LAT-1];
            rgb_vs <= vs_sr[RD_LAT-1];
            if (pix_ok) begin
                rgb_r <= {video_data[15:11], video_data[15:13]};
                rgb_g <= {video_data[10:5],  video_data[10:9]};
                rgb_b <= {video_data[4:0],   video_data[4:2]};
            end else begin
                rgb_r <= '0;
                rgb_g <= '0;
                rgb_b <= '0;
            end
        end
    end

    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
            err_cnt   <= '0;
        end else if (err_clr) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (de_d && !video_de)
                underflow <= 1'b1;
            if (video_de && !de_d)
                overflow <= 1'b1;
            if (mismatch && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_vo_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vo_timing_gen
//
// Bench for vo_timing_gen on a reduced raster (17x10 total, 8x4 active) so
// several whole frames fit in a short run. A DMA model answers vo_de after
// two cycles and pushes the expected RGB888 result for every answered
// request into a scoreboard, which is compared against rgb_* on every cycle.
// ---------------------------------------------------------------------------
module tb_vo_timing_gen;

    localparam int H_DISP = 8;
    localparam int H_FP   = 3;
    localparam int H_SYNC = 2;
    localparam int H_BP   = 4;
    localparam int V_DISP = 4;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 2;
    localparam int RD_LAT = 2;
    localparam int HT     = 17;
    localparam int FRAME  = 170;

    logic        video_clk;
    logic        rst;
    logic        enable;
    logic        err_clr;
    logic        vo_vs;
    logic        vo_de;
    logic        video_de;
    logic [15:0] video_data;
    logic        rgb_vs;
    logic        rgb_hs;
    logic        rgb_de;
    logic [7:0]  rgb_r;
    logic [7:0]  rgb_g;
    logic [7:0]  rgb_b;
    logic        running;
    logic        underflow;
    logic        overflow;
    logic [15:0] err_cnt;

    vo_timing_gen #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .RD_LAT(RD_LAT)
    ) dut (
        .video_clk (video_clk),
        .rst       (rst),
        .enable    (enable),
        .err_clr   (err_clr),
        .vo_vs     (vo_vs),
        .vo_de     (vo_de),
        .video_de  (video_de),
        .video_data(video_data),
        .rgb_vs    (rgb_vs),
        .rgb_hs    (rgb_hs),
        .rgb_de    (rgb_de),
        .rgb_r     (rgb_r),
        .rgb_g     (rgb_g),
        .rgb_b     (rgb_b),
        .running   (running),
        .underflow (underflow),
        .overflow  (overflow),
        .err_cnt   (err_cnt)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        video_clk = 1'b0;
        forever #5 video_clk = ~video_clk;
    end

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [63:0] outs();
        return {16'b0, vo_vs, vo_de, rgb_vs, rgb_hs, rgb_de, rgb_r, rgb_g, rgb_b,
                running, underflow, overflow, err_cnt};
    endfunction

    function automatic logic [63:0] flags();
        return {46'b0, underflow, overflow, err_cnt};
    endfunction

    function automatic logic [23:0] expand(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return vo_de;
            1:       return rgb_de;
            2:       return vo_vs;
            default: return running;
        endcase
    endfunction

    // ---------------- DMA model and scoreboard ----------------
    typedef struct {
        int          due;
        logic [24:0] v;
    } exp_t;

    exp_t        sbq[$];
    int          cyc      = 0;
    int          drop_cnt = 0;
    bit          inject   = 0;
    bit          force_en = 0;
    logic [15:0] force_val = 16'h0;
    logic [15:0] pat       = 16'h1234;

    initial begin
        logic [1:0]  hist;
        logic        req;
        logic [15:0] d;
        logic [24:0] want;
        hist       = '0;
        video_de   = 1'b0;
        video_data = 16'h0;
        forever begin
            @(negedge video_clk);
            cyc++;
            if (rst) begin
                sbq.delete();
                hist       = '0;
                video_de   = 1'b0;
                video_data = 16'h0;
            end else begin
                want = '0;
                if (sbq.size() > 0 && sbq[0].due == cyc) begin
                    want = sbq[0].v;
                    void'(sbq.pop_front());
                end
                chk("pixel", {39'b0, rgb_de, rgb_r, rgb_g, rgb_b}, {39'b0, want});

                req  = hist[1];
                hist = {hist[0], vo_de};
                if (req) begin
                    d   = force_en ? force_val : pat;
                    pat = pat + 16'h0843;
                    if (drop_cnt > 0) begin
                        drop_cnt--;
                        video_de   = 1'b0;
                        video_data = 16'h0;
                        sbq.push_back('{due: cyc + 1, v: {1'b1, 24'h0}});
                    end else begin
                        video_de   = 1'b1;
                        video_data = d;
                        sbq.push_back('{due: cyc + 1, v: {1'b1, expand(d)}});
                    end
                end else if (inject) begin
                    inject     = 0;
                    video_de   = 1'b1;
                    video_data = 16'hBEEF;
                end else begin
                    video_de   = 1'b0;
                    video_data = 16'h0;
                end
            end
        end
    end

    task automatic wait_for(input int sel, input logic val, input string tag);
        bit hit = 0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            if (sel_sig(sel) === val) begin
                hit = 1;
                break;
            end
            @(negedge video_clk);
        end
        chk(tag, {63'b0, hit}, 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  de_hi, vs_hi, hs_hi, rvs_hi, rde_hi;
        int  f_vs, f_rde, f_rhs, f_rvs, run1, low1, rise2, phase;
        int  rc, dc;
        logic prev_de;

        rst     = 1'b1;
        enable  = 1'b0;
        err_clr = 1'b0;

        repeat (3) @(negedge video_clk);
        chk("reset_outs", outs(), 64'h0);

        // Start: one edge into RUN, vo_de one edge later.
        #2 rst = 1'b0;
        enable = 1'b1;
        @(negedge video_clk);
        chk("running_first", {63'b0, running}, 64'd1);
        chk("vo_de_first_low", {63'b0, vo_de}, 64'd0);
        @(negedge video_clk);
        chk("vo_de_rise", {63'b0, vo_de}, 64'd1);

        // One full frame of raster measurement, index 0 = first vo_de cycle.
        de_hi = 0; vs_hi = 0; hs_hi = 0; rvs_hi = 0; rde_hi = 0;
        f_vs = -1; f_rde = -1; f_rhs = -1; f_rvs = -1;
        run1 = 0; low1 = 0; rise2 = -1; phase = 0; prev_de = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            if (vo_de)  de_hi++;
            if (vo_vs)  vs_hi++;
            if (rgb_hs) hs_hi++;
            if (rgb_vs) rvs_hi++;
            if (rgb_de) rde_hi++;
            if (vo_vs  && f_vs  < 0) f_vs  = i;
            if (rgb_de && f_rde < 0) f_rde = i;
            if (rgb_hs && f_rhs < 0) f_rhs = i;
            if (rgb_vs && f_rvs < 0) f_rvs = i;
            if (phase == 0) begin
                if (vo_de) run1++;
                else begin phase = 1; low1++; end
            end else if (phase == 1) begin
                if (!vo_de) low1++;
                else phase = 2;
            end
            if (i > 0 && vo_de && !prev_de && rise2 < 0) rise2 = i;
            prev_de = vo_de;
            @(negedge video_clk);
        end
        chk("vo_de_frame_cnt",  64'(de_hi),  64'd32);
        chk("rgb_de_frame_cnt", 64'(rde_hi), 64'd32);
        chk("vo_vs_frame_cnt",  64'(vs_hi),  64'd34);
        chk("rgb_vs_frame_cnt", 64'(rvs_hi), 64'd34);
        chk("rgb_hs_frame_cnt", 64'(hs_hi),  64'd20);
        chk("vo_vs_start",      64'(f_vs),   64'd102);
        chk("rgb_de_lag",       64'(f_rde),  64'd3);
        chk("rgb_hs_start",     64'(f_rhs),  64'd14);
        chk("rgb_vs_start",     64'(f_rvs),  64'd105);
        chk("vo_de_line_high",  64'(run1),   64'd8);
        chk("vo_de_line_low",   64'(low1),   64'd9);
        chk("line_period",      64'(rise2),  64'(HT));
        chk("clean_frame_flags", flags(), 64'h0);

        // Pixel expansion with fixed DMA data, switched between lines.
        wait_for(1, 1'b1, "wait_rgb_de_a");
        wait_for(1, 1'b0, "wait_rgb_de_b");
        force_en  = 1;
        force_val = 16'hF81F;
        wait_for(1, 1'b1, "wait_rgb_de_c");
        chk("expand_F81F", {40'b0, rgb_r, rgb_g, rgb_b}, 64'hFF00FF);
        wait_for(1, 1'b0, "wait_rgb_de_d");
        force_val = 16'h0841;
        wait_for(1, 1'b1, "wait_rgb_de_e");
        // green field of 0x0841 is 6'b000010, which expands to 0x08
        chk("expand_0841", {40'b0, rgb_r, rgb_g, rgb_b}, 64'h080808);
        wait_for(1, 1'b0, "wait_rgb_de_f");
        force_en = 0;

        // Underflow: three dropped returns mid-line.
        wait_for(0, 1'b0, "wait_vo_de_a");
        wait_for(0, 1'b1, "wait_vo_de_b");
        repeat (2) @(negedge video_clk);
        drop_cnt = 3;
        repeat (12) @(negedge video_clk);
        chk("underflow_flags", flags(), {46'b0, 1'b1, 1'b0, 16'd3});
        @(negedge video_clk);
        err_clr = 1'b1;
        @(negedge video_clk);
        err_clr = 1'b0;
        chk("clear_after_uf", flags(), 64'h0);

        // Clear held across a new mismatch: clear wins.
        wait_for(0, 1'b0, "wait_vo_de_c");
        wait_for(0, 1'b1, "wait_vo_de_d");
        err_clr  = 1'b1;
        drop_cnt = 1;
        repeat (8) @(negedge video_clk);
        err_clr = 1'b0;
        @(negedge video_clk);
        chk("clear_wins", flags(), 64'h0);

        // Overflow: spurious return during vertical sync.
        wait_for(2, 1'b1, "wait_vo_vs_a");
        inject = 1;
        repeat (4) @(negedge video_clk);
        chk("overflow_flags", flags(), {46'b0, 1'b0, 1'b1, 16'd1});
        chk("overflow_no_de", {63'b0, rgb_de}, 64'd0);
        @(negedge video_clk);
        err_clr = 1'b1;
        @(negedge video_clk);
        err_clr = 1'b0;
        chk("clear_after_of", flags(), 64'h0);

        // Stop request on line 2 of a frame: the frame still completes.
        wait_for(2, 1'b0, "wait_vo_vs_b");
        wait_for(0, 1'b1, "wait_vo_de_e");
        repeat (2 * HT) @(negedge video_clk);
        enable = 1'b0;
        rc = 0;
        dc = 0;
        for (int n = 0; n < 134; n++) begin
            @(negedge video_clk);
            if (running) rc++;
            if (vo_de)   dc++;
        end
        chk("running_to_end", 64'(rc), 64'd134);
        chk("vo_de_rest_of_frame", 64'(dc), 64'd15);
        @(negedge video_clk);
        chk("running_fall", {63'b0, running}, 64'd0);
        rc = 0;
        dc = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge video_clk);
            if (running) rc++;
            if (vo_de)   dc++;
        end
        chk("idle_running", 64'(rc), 64'd0);
        chk("idle_vo_de", 64'(dc), 64'd0);

        // Restart, then reset mid-line.
        enable = 1'b1;
        inject = 1;
        wait_for(0, 1'b1, "wait_vo_de_f");
        chk("overflow_before_rst", {63'b0, overflow}, 64'd1);
        repeat (3) @(negedge video_clk);
        chk("rgb_de_before_rst", {63'b0, rgb_de}, 64'd1);
        #2 rst = 1'b1;
        #1 chk("async_reset_outs", outs(), 64'h0);
        @(negedge video_clk);
        #2 rst = 1'b0;
        @(negedge video_clk);
        chk("restart_running", {63'b0, running}, 64'd1);
        chk("restart_vo_de_low", {63'b0, vo_de}, 64'd0);
        @(negedge video_clk);
        chk("restart_vo_de", {63'b0, vo_de}, 64'd1);
        repeat (20) @(negedge video_clk);
        chk("restart_flags", flags(), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
